// File: rtl/mem_stage_pkg.sv
// Shared pipeline types for the memory stage: control encodings, stage payloads
// and the bus FSM state enum.
package mem_stage_pkg;

  localparam logic [1:0] MEM_NUL   = 2'b00;
  localparam logic [1:0] MEM_WRITE = 2'b01;
  localparam logic [1:0] MEM_READ  = 2'b10;

  typedef struct packed {
    logic [1:0]  memory_valid;
    logic        reg_write;
    logic [11:0] misc;
  } ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] alu_out;
    ctl_t        ctl;
    logic [63:0] dreq_data;
    logic [63:0] dout;
    logic [4:0]  dst;
    logic [3:0]  cc;
  } execute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] m_write_addr;
    logic [63:0] m_read_data;
    logic [63:0] alu_out;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic [3:0]  cc;
  } memory_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // 2'b11 is deliberately not a memory op; it behaves like NUL.
  function automatic logic is_mem_op(input logic [1:0] mv);
    return (mv == MEM_WRITE) || (mv == MEM_READ);
  endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// Data-bus sequencer: tracks IDLE/REQ/WAIT/DONE, drives the request channel and
// captures read data on completion.
module mem_bus_fsm
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  in_mem_valid,
  input  logic        out_ready,
  input  logic [1:0]  ent_mem_valid,
  input  logic [63:0] ent_addr,
  input  logic [63:0] ent_wdata,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output mem_state_t  state,
  output logic        in_ready,
  output logic        accept,
  output logic        out_valid,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  output logic [63:0] rdata
);

  mem_state_t  state_q, state_d;
  logic [63:0] rdata_q, rdata_d;
  logic        complete;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept      = in_valid && in_ready;
    out_valid   = (state_q == DONE);
    dreq_valid  = (state_q == REQ);
    dreq_size   = 3'b011;
    dreq_addr   = '0;
    dreq_strobe = '0;
    dreq_data   = '0;
    complete    = ((state_q == REQ) && dresp_addr_ok && dresp_data_ok) ||
                  ((state_q == WAIT) && dresp_data_ok);

    // Request fields come straight from the held entry, so they stay stable in REQ.
    if (state_q == REQ) begin
      dreq_addr   = ent_addr;
      dreq_strobe = (ent_mem_valid == MEM_WRITE) ? 8'hFF : 8'h00;
      dreq_data   = ent_wdata;
    end

    if (complete && (ent_mem_valid == MEM_READ)) rdata_d = dresp_data;

    case (state_q)
      IDLE: if (accept) state_d = is_mem_op(in_mem_valid) ? REQ : DONE;
      REQ:  if (dresp_addr_ok) state_d = dresp_data_ok ? DONE : WAIT;
      WAIT: if (dresp_data_ok) state_d = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) state_d = is_mem_op(in_mem_valid) ? REQ : DONE;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state = state_q;
  assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// RV64 memory stage: holds one execute entry, runs its LD/SD through the bus FSM
// and presents the result to writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  execute_data_t          in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output memory_data_t           out_data,
  input  logic                   out_ready,
  output logic                   dreq_valid,
  output logic [63:0]            dreq_addr,
  output logic [2:0]             dreq_size,
  output logic [7:0]             dreq_strobe,
  output logic [63:0]            dreq_data,
  input  logic                   dresp_addr_ok,
  input  logic                   dresp_data_ok,
  input  logic [63:0]            dresp_data,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  execute_data_t          ent_q, ent_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  mem_state_t             state;
  logic                   accept;
  logic [63:0]            rdata;

  mem_bus_fsm u_fsm (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_mem_valid  (in_data.ctl.memory_valid),
    .out_ready     (out_ready),
    .ent_mem_valid (ent_q.ctl.memory_valid),
    .ent_addr      (ent_q.alu_out),
    .ent_wdata     (ent_q.dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .state         (state),
    .in_ready      (in_ready),
    .accept        (accept),
    .out_valid     (out_valid),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .rdata         (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_q   <= '0;
      stall_q <= '0;
    end else begin
      ent_q   <= ent_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    ent_d   = accept ? in_data : ent_q;
    stall_d = stall_q;
    // Saturate rather than wrap so a long-running total never reads as small.
    if (((state == REQ) || (state == WAIT)) && (stall_q != {STALL_CNT_W{1'b1}}))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_comb begin
    out_data              = '0;
    out_data.pc           = ent_q.pc;
    out_data.m_write_addr = ent_q.alu_out;
    out_data.m_read_data  = (ent_q.ctl.memory_valid == MEM_READ) ? rdata : 64'd0;
    out_data.alu_out      = ent_q.alu_out;
    out_data.ctl          = ent_q.ctl;
    out_data.dst          = ent_q.dst;
    out_data.cc           = ent_q.cc;
  end

  assign stall_cycles = stall_q;

endmodule
